// File: rtl/bp_pkg.sv
// Shared types for the branch-predictor table port arbiter:
// the table index width, the queued update entry and the arbiter FSM states.
package bp_pkg;

    localparam int PC_W = 10;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            taken;
    } upd_entry_t;

    typedef enum logic {
        S_NORM  = 1'b0,
        S_FORCE = 1'b1
    } arb_state_t;

endpackage

// File: rtl/bp_upd_fifo.sv
// Update FIFO for the prediction-table port arbiter.
// Holds resolve updates in enqueue order; pointers wrap modulo DEPTH.
// With BP_UPD_COALESCE_EN defined it also exposes the tail entry and lets
// the arbiter overwrite the tail's taken bit in place.
module bp_upd_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 8
)
(
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  upd_entry_t push_data,
    input  logic       pop,
`ifdef BP_UPD_COALESCE_EN
    input  logic       tail_wr,
    input  logic       tail_taken,
    output upd_entry_t tail,
    output logic       tail_is_head,
`endif
    output upd_entry_t head,
    output logic       empty,
    output logic       full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    upd_entry_t     mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           full_q, full_d;

    // Next pointer, occupancy and full flag from this cycle's push/pop.
    // NOTE: every signal assigned here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);
        full_d = (count_d == CW'(DEPTH));
    end

    // Pointer/occupancy registers; reset empties the queue.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

`ifdef BP_UPD_COALESCE_EN
    logic [AW-1:0] tail_idx;
    assign tail_idx     = wr_ptr_q - AW'(1);
    assign tail         = mem_q[tail_idx];
    assign tail_is_head = (count_q == CW'(1));
`endif

    // Entry storage: write on push, or patch the tail's outcome on coalesce.
    // NOTE: storage has no reset; empty/full come from the reset counters,
    // so stale contents are never observed.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
`ifdef BP_UPD_COALESCE_EN
        else if (tail_wr) begin
            mem_q[tail_idx].taken <= tail_taken;
        end
`endif
    end

    assign head  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = full_q;

endmodule

// File: rtl/bp_table_port_arbiter.sv
// Owns the single read/write port of the tournament predictor tables.
// Fetch lookups win by default; resolve updates queue in bp_upd_fifo and
// drain on idle cycles. After STARVE_LIMIT lookup grants with updates
// pending, one cycle is forced to an update (lk_ready drops for that cycle).
// Optional: define BP_UPD_COALESCE_EN to merge an update into a matching
// tail entry instead of enqueuing it.
module bp_table_port_arbiter
    import bp_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int STARVE_LIMIT = 4
)
(
    input  logic            clock,
    input  logic            reset,
    input  logic            lk_valid,
    input  logic [PC_W-1:0] lk_pc,
    output logic            lk_ready,
    output logic            lk_rsp_valid,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    output logic            upd_ready,
    output logic            tbl_en,
    output logic            tbl_we,
    output logic [PC_W-1:0] tbl_addr,
    output logic            tbl_wdata
);

    localparam int SCW = $clog2(STARVE_LIMIT + 1);

    arb_state_t      state_q, state_d;
    logic [SCW-1:0]  starve_cnt_q, starve_cnt_d;
    logic            tbl_en_q, tbl_en_d;
    logic            tbl_we_q, tbl_we_d;
    logic [PC_W-1:0] tbl_addr_q, tbl_addr_d;
    logic            tbl_wdata_q, tbl_wdata_d;
    logic            lk_rsp_valid_q, lk_rsp_valid_d;

    logic            grant_lk, grant_upd;
    logic            fifo_push, fifo_empty, fifo_full;
    logic            upd_accept, tail_match;
    upd_entry_t      fifo_head;
    upd_entry_t      push_entry;

    assign push_entry = '{pc: upd_pc, taken: upd_taken};

`ifdef BP_UPD_COALESCE_EN
    upd_entry_t      fifo_tail;
    logic            fifo_tail_is_head;
    // A matching tail can absorb the update unless it leaves the queue now.
    assign tail_match = !fifo_empty && (fifo_tail.pc == upd_pc)
                        && !(grant_upd && fifo_tail_is_head);
`else
    assign tail_match = 1'b0;
`endif

    assign upd_ready  = !fifo_full || tail_match;
    assign upd_accept = upd_valid && upd_ready;
    assign fifo_push  = upd_accept && !tail_match;
    assign lk_ready   = (state_q == S_NORM);

    bp_upd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock        (clock),
        .reset        (reset),
        .push         (fifo_push),
        .push_data    (push_entry),
        .pop          (grant_upd),
`ifdef BP_UPD_COALESCE_EN
        .tail_wr      (upd_accept && tail_match),
        .tail_taken   (upd_taken),
        .tail         (fifo_tail),
        .tail_is_head (fifo_tail_is_head),
`endif
        .head         (fifo_head),
        .empty        (fifo_empty),
        .full         (fifo_full)
    );

    // Port grant: lookups first in S_NORM, FIFO head on idle or forced cycles.
    always_comb begin
        grant_lk  = 1'b0;
        grant_upd = 1'b0;
        if (state_q == S_NORM) begin
            if (lk_valid)         grant_lk  = 1'b1;
            else if (!fifo_empty) grant_upd = 1'b1;
        end else begin
            grant_upd = 1'b1;
        end
    end

    // Next FSM state, starvation count and table-port outputs.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        if (grant_upd || fifo_empty) begin
            starve_cnt_d = '0;
        end else if (grant_lk && starve_cnt_q != SCW'(STARVE_LIMIT)) begin
            starve_cnt_d = starve_cnt_q + SCW'(1);
        end
        case (state_q)
            S_NORM: begin
                if (grant_lk && !fifo_empty
                    && starve_cnt_q == SCW'(STARVE_LIMIT - 1)) begin
                    state_d = S_FORCE;
                end
            end
            default: state_d = S_NORM;
        endcase

        tbl_en_d    = grant_lk || grant_upd;
        tbl_we_d    = grant_upd;
        tbl_addr_d  = '0;
        tbl_wdata_d = 1'b0;
        if (grant_upd) begin
            tbl_addr_d  = fifo_head.pc;
            tbl_wdata_d = fifo_head.taken;
        end else if (grant_lk) begin
            tbl_addr_d  = lk_pc;
        end
        // Read data is valid the edge after the read was issued.
        lk_rsp_valid_d = tbl_en_q && !tbl_we_q;
    end

    // Arbiter FSM with registered table-port outputs; reset drops any
    // in-flight access.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= S_NORM;
            starve_cnt_q   <= '0;
            tbl_en_q       <= 1'b0;
            tbl_we_q       <= 1'b0;
            tbl_addr_q     <= '0;
            tbl_wdata_q    <= 1'b0;
            lk_rsp_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            starve_cnt_q   <= starve_cnt_d;
            tbl_en_q       <= tbl_en_d;
            tbl_we_q       <= tbl_we_d;
            tbl_addr_q     <= tbl_addr_d;
            tbl_wdata_q    <= tbl_wdata_d;
            lk_rsp_valid_q <= lk_rsp_valid_d;
        end
    end

    assign tbl_en       = tbl_en_q;
    assign tbl_we       = tbl_we_q;
    assign tbl_addr     = tbl_addr_q;
    assign tbl_wdata    = tbl_wdata_q;
    assign lk_rsp_valid = lk_rsp_valid_q;

endmodule

// File: tb/tb_bp_table_port_arbiter.sv
// Directed bench for bp_table_port_arbiter (DEPTH=8, STARVE_LIMIT=4).
// Inputs change 1ns after a rising edge; outputs are sampled at that point.
module tb_bp_table_port_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic       lk_valid;
    logic [9:0] lk_pc;
    logic       lk_ready;
    logic       lk_rsp_valid;
    logic       upd_valid;
    logic [9:0] upd_pc;
    logic       upd_taken;
    logic       upd_ready;
    logic       tbl_en;
    logic       tbl_we;
    logic [9:0] tbl_addr;
    logic       tbl_wdata;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    bp_table_port_arbiter #(
        .DEPTH        (8),
        .STARVE_LIMIT (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .lk_valid     (lk_valid),
        .lk_pc        (lk_pc),
        .lk_ready     (lk_ready),
        .lk_rsp_valid (lk_rsp_valid),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_taken    (upd_taken),
        .upd_ready    (upd_ready),
        .tbl_en       (tbl_en),
        .tbl_we       (tbl_we),
        .tbl_addr     (tbl_addr),
        .tbl_wdata    (tbl_wdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_port(input string tag, input logic en, input logic we,
                              input logic [9:0] addr, input logic wd);
        check({tag, "_en"}, 32'(tbl_en), 32'(en));
        check({tag, "_we"}, 32'(tbl_we), 32'(we));
        check({tag, "_addr"}, 32'(tbl_addr), 32'(addr));
        check({tag, "_wdata"}, 32'(tbl_wdata), 32'(wd));
    endtask

    logic [9:0] drain_exp [7];

    initial begin
        drain_exp = '{10'h203, 10'h204, 10'h205, 10'h206, 10'h207, 10'h208, 10'h2FF};

        reset = 1'b1; lk_valid = 1'b0; lk_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
        #3;
        check_port("rst", 1'b0, 1'b0, 10'h000, 1'b0);
        check("rst_rsp", 32'(lk_rsp_valid), 32'd0);
        check("rst_upd_ready", 32'(upd_ready), 32'd1);
        check("rst_lk_ready", 32'(lk_ready), 32'd1);
        tick(); tick();
        reset = 1'b0;

        // 1: single lookup, response two cycles after the request cycle
        lk_valid = 1'b1; lk_pc = 10'h3A0;
        #1;
        check("t1_lk_ready", 32'(lk_ready), 32'd1);
        tick();
        check_port("t1_grant", 1'b1, 1'b0, 10'h3A0, 1'b0);
        check("t1_rsp_early", 32'(lk_rsp_valid), 32'd0);
        lk_valid = 1'b0;
        tick();
        check("t1_rsp", 32'(lk_rsp_valid), 32'd1);
        check("t1_idle_en", 32'(tbl_en), 32'd0);
        tick();
        check("t1_rsp_off", 32'(lk_rsp_valid), 32'd0);

        // 2: update on an idle port, written two edges after acceptance
        upd_valid = 1'b1; upd_pc = 10'h012; upd_taken = 1'b1;
        tick();
        upd_valid = 1'b0;
        check("t2_no_bypass", 32'(tbl_en), 32'd0);
        tick();
        check_port("t2_write", 1'b1, 1'b1, 10'h012, 1'b1);
        check("t2_upd_ready", 32'(upd_ready), 32'd1);
        tick();
        check("t2_drained_en", 32'(tbl_en), 32'd0);
        check("t2_no_rsp", 32'(lk_rsp_valid), 32'd0);

        // 3: starvation guard forces one update after 4 blocked lookups
        lk_valid = 1'b1; lk_pc = 10'h100;
        upd_valid = 1'b1; upd_pc = 10'h0AB; upd_taken = 1'b0;
        tick();
        upd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t3_lk_ready", 32'(lk_ready), 32'd1);
            tick();
            check_port("t3_lookup", 1'b1, 1'b0, 10'h100, 1'b0);
        end
        check("t3_forced", 32'(lk_ready), 32'd0);
        tick();
        check_port("t3_force_wr", 1'b1, 1'b1, 10'h0AB, 1'b0);
        check("t3_resume", 32'(lk_ready), 32'd1);
        tick();
        check_port("t3_lookup2", 1'b1, 1'b0, 10'h100, 1'b0);
        lk_valid = 1'b0;
        tick(); tick();

        // 4: fill to full under held lookups, with one forced drain on the way
        lk_valid = 1'b1; lk_pc = 10'h101;
        upd_valid = 1'b1; upd_taken = 1'b1;
        for (int i = 0; i < 9; i++) begin
            upd_pc = 10'h200 + 10'(i);
            check("t4_fill_ready", 32'(upd_ready), 32'd1);
            tick();
            if (i == 4) check("t4_force_gap", 32'(lk_ready), 32'd0);
            if (i == 5) check_port("t4_force_pop", 1'b1, 1'b1, 10'h200, 1'b1);
        end
        check("t4_full", 32'(upd_ready), 32'd0);
        upd_pc = 10'h2FF;
        tick();
        check("t4_held", 32'(upd_ready), 32'd0);
        check("t4_force2", 32'(lk_ready), 32'd0);
        check_port("t4_lookup", 1'b1, 1'b0, 10'h101, 1'b0);
        tick();
        check_port("t4_pop201", 1'b1, 1'b1, 10'h201, 1'b1);
        check("t4_slot_free", 32'(upd_ready), 32'd1);
        lk_valid = 1'b0;
        tick();
        check_port("t4_pop202", 1'b1, 1'b1, 10'h202, 1'b1);
        check("t4_push_pop_ready", 32'(upd_ready), 32'd1);
        upd_valid = 1'b0;
        for (int j = 0; j < 7; j++) begin
            tick();
            check_port("t4_drain", 1'b1, 1'b1, drain_exp[j], 1'b1);
        end
        tick();
        check("t4_empty_en", 32'(tbl_en), 32'd0);

        // 5: reset mid-operation discards the queue and the in-flight read
        lk_valid = 1'b1; lk_pc = 10'h0F0;
        upd_valid = 1'b1; upd_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            upd_pc = 10'h031 + 10'(i);
            tick();
        end
        upd_valid = 1'b0;
        tick();
        check_port("t5_pre", 1'b1, 1'b0, 10'h0F0, 1'b0);
        check("t5_pre_rsp", 32'(lk_rsp_valid), 32'd1);
        reset = 1'b1;
        #1;
        check_port("t5_rst", 1'b0, 1'b0, 10'h000, 1'b0);
        check("t5_rst_rsp", 32'(lk_rsp_valid), 32'd0);
        check("t5_rst_upd_ready", 32'(upd_ready), 32'd1);
        check("t5_rst_lk_ready", 32'(lk_ready), 32'd1);
        lk_valid = 1'b0;
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_no_access", 32'(tbl_en), 32'd0);
            check("t5_no_rsp", 32'(lk_rsp_valid), 32'd0);
        end

        // 6: same-pc updates back to back while lookups hold the port
        lk_valid = 1'b1; lk_pc = 10'h001;
        upd_valid = 1'b1; upd_pc = 10'h055; upd_taken = 1'b0;
        tick();
        upd_taken = 1'b1;
        tick();
        lk_valid = 1'b0; upd_valid = 1'b0;
        tick();
`ifdef BP_UPD_COALESCE_EN
        check_port("t6_merged", 1'b1, 1'b1, 10'h055, 1'b1);
        tick();
        check("t6_single_write", 32'(tbl_en), 32'd0);
`else
        check_port("t6_first", 1'b1, 1'b1, 10'h055, 1'b0);
        tick();
        check_port("t6_second", 1'b1, 1'b1, 10'h055, 1'b1);
`endif
        tick();
        check("t6_idle", 32'(tbl_en), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
